mem_read_arbiter: RTL and testbench

Shares the single packet-memory read port among `NUM_PORTS` per-port memory read controllers, one read issued per cycle with round-robin fairness. It sits directly upstream of the output stage: it consumes each port's `re`/`addr` request and produces the per-port `rvalid`/`rdata` beats the read controllers wait on. Each in-flight read is tracked through the memory latency so that returned data is steered to the requesting port only.

---
 rtl/mem_read_arbiter_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/mem_read_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_read_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// mem_read_arbiter_pkg: shared sizes and the read-tag payload for the packet-memory read arbiter.
// Values mirror the switch, rx/tx and memory packages of the surrounding design.
package mem_read_arbiter_pkg;

    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned BLOCK_BYTES    = 4;
    localparam int unsigned DATA_WIDTH     = 8;
    localparam int unsigned NUM_PORTS      = 4;
    localparam int unsigned MEM_RD_LATENCY = 1;

    localparam int unsigned PORT_ID_W      = $clog2(NUM_PORTS);

    // One in-flight read: travels alongside the memory access to steer returned data.
    typedef struct packed {
        logic                 valid;
        logic [PORT_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; the search starts at ptr_i and wraps at N-1.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] idx;

    // Walk the eligibility vector from the pointer and take the first hit.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = ptr_i;
        for (int unsigned i = 0; i < N; i++) begin
            if (!gnt_valid_o && elig_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
            end
            idx = (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares the packet-memory read port among NUM_PORTS requesters,
// one read per cycle, round-robin, with returned data steered back by a tag pipeline.
// Config macro MEM_RD_ARB_OUT_REG_EN: registers req_rvalid_o/req_rdata_o (one extra cycle).
module mem_read_arbiter #(
    parameter int unsigned ADDR_W         = mem_read_arbiter_pkg::ADDR_W,
    parameter int unsigned BLOCK_BYTES    = mem_read_arbiter_pkg::BLOCK_BYTES,
    parameter int unsigned DATA_WIDTH     = mem_read_arbiter_pkg::DATA_WIDTH,
    parameter int unsigned NUM_PORTS      = mem_read_arbiter_pkg::NUM_PORTS,
    parameter int unsigned MEM_RD_LATENCY = mem_read_arbiter_pkg::MEM_RD_LATENCY
) (
    input  logic                                switch_clk,
    input  logic                                switch_rst_n,
    input  logic [NUM_PORTS-1:0]                req_re_i,
    input  logic [ADDR_W-1:0]                   req_addr_i  [NUM_PORTS],
    output logic [NUM_PORTS-1:0]                req_rvalid_o,
    output logic [BLOCK_BYTES*DATA_WIDTH-1:0]   req_rdata_o [NUM_PORTS],
    output logic                                mem_re_o,
    output logic [ADDR_W-1:0]                   mem_raddr_o,
    input  logic [BLOCK_BYTES*DATA_WIDTH-1:0]   mem_rdata_i
);

    import mem_read_arbiter_pkg::*;

    localparam int unsigned ID_W     = $clog2(NUM_PORTS);
    localparam int unsigned TAG_ID_W = $bits(rd_tag_t) - 1;
    localparam int unsigned BLOCK_W  = BLOCK_BYTES * DATA_WIDTH;

    logic [NUM_PORTS-1:0] busy_q, busy_d;
    logic [NUM_PORTS-1:0] elig_c;
    logic [NUM_PORTS-1:0] rvalid_c;
    logic [NUM_PORTS-1:0] done_c;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      issue_id_q, issue_id_d;
    logic [ID_W-1:0]      gnt_idx_c;
    logic                 gnt_valid_c;
    logic                 mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]    mem_raddr_q, mem_raddr_d;
    rd_tag_t              pipe_q [MEM_RD_LATENCY];
    rd_tag_t              pipe_d [MEM_RD_LATENCY];
    rd_tag_t              tag_out_c;
    logic [BLOCK_W-1:0]   rdata_c [NUM_PORTS];

    // A port already holding an unreturned read is not offered again until its rvalid cycle ends.
    assign elig_c    = req_re_i & ~busy_q;
    assign tag_out_c = pipe_q[MEM_RD_LATENCY-1];

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .elig_i      (elig_c),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid_c),
        .gnt_idx_o   (gnt_idx_c)
    );

    // Steer the returning memory data to the port named by the tag; all others see zero.
    always_comb begin
        rvalid_c = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rdata_c[p] = '0;
            if (tag_out_c.valid && (tag_out_c.id == TAG_ID_W'(p))) begin
                rvalid_c[p] = 1'b1;
                rdata_c[p]  = mem_rdata_i;
            end
        end
    end

`ifdef MEM_RD_ARB_OUT_REG_EN
    logic [NUM_PORTS-1:0] rvalid_q;
    logic [BLOCK_W-1:0]   rdata_q [NUM_PORTS];

    // Output register stage for the returned beats.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            rvalid_q <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rdata_q[p] <= '0;
            end
        end else begin
            rvalid_q <= rvalid_c;
            rdata_q  <= rdata_c;
        end
    end

    assign done_c       = rvalid_q;
    assign req_rvalid_o = rvalid_q;
    assign req_rdata_o  = rdata_q;
`else
    assign done_c       = rvalid_c;
    assign req_rvalid_o = rvalid_c;
    assign req_rdata_o  = rdata_c;
`endif

    // Grant, pointer advance, issue and tag-shift next-state.
    always_comb begin
        busy_d      = busy_q & ~done_c;
        rr_ptr_d    = rr_ptr_q;
        mem_re_d    = 1'b0;
        mem_raddr_d = mem_raddr_q;
        issue_id_d  = issue_id_q;
        if (gnt_valid_c) begin
            busy_d[gnt_idx_c] = 1'b1;
            rr_ptr_d          = (gnt_idx_c == ID_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_c + 1'b1;
            mem_re_d          = 1'b1;
            mem_raddr_d       = req_addr_i[gnt_idx_c];
            issue_id_d        = gnt_idx_c;
        end
        pipe_d[0].valid = mem_re_q;
        pipe_d[0].id    = TAG_ID_W'(issue_id_q);
        for (int unsigned i = 1; i < MEM_RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge switch_clk or negedge switch_rst_n) begin
        if (!switch_rst_n) begin
            busy_q      <= '0;
            rr_ptr_q    <= '0;
            mem_re_q    <= 1'b0;
            mem_raddr_q <= '0;
            issue_id_q  <= '0;
            for (int unsigned i = 0; i < MEM_RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_re_q    <= mem_re_d;
            mem_raddr_q <= mem_raddr_d;
            issue_id_q  <= issue_id_d;
            pipe_q      <= pipe_d;
        end
    end

    assign mem_re_o    = mem_re_q;
    assign mem_raddr_o = mem_raddr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: scoreboard bench for mem_read_arbiter at NUM_PORTS=4, MEM_RD_LATENCY=1.
module tb_mem_read_arbiter;

    localparam int unsigned NP = mem_read_arbiter_pkg::NUM_PORTS;
    localparam int unsigned AW = mem_read_arbiter_pkg::ADDR_W;
    localparam int unsigned DW = mem_read_arbiter_pkg::BLOCK_BYTES * mem_read_arbiter_pkg::DATA_WIDTH;
`ifdef MEM_RD_ARB_OUT_REG_EN
    localparam int OL = 1;
`else
    localparam int OL = 0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [NP-1:0]     re    = '0;
    logic [AW-1:0]     addr  [NP];
    logic [NP-1:0]     rvalid;
    logic [DW-1:0]     rdata [NP];
    logic              mem_re;
    logic [AW-1:0]     mem_raddr;
    logic [DW-1:0]     mem_rdata = '0;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct { int cyc; int port; logic [DW-1:0] data; } rd_exp_t;
    typedef struct { int cyc; logic [AW-1:0] addr; } iss_exp_t;
    rd_exp_t  rd_q  [$];
    iss_exp_t iss_q [$];

    mem_read_arbiter u_dut (
        .switch_clk   (clk),
        .switch_rst_n (rst_n),
        .req_re_i     (re),
        .req_addr_i   (addr),
        .req_rvalid_o (rvalid),
        .req_rdata_o  (rdata),
        .mem_re_o     (mem_re),
        .mem_raddr_o  (mem_raddr),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        logic [4*AW-1:0] w;
        w = {a, ~a, a + AW'(7), a ^ AW'(8'h5A)};
        return DW'(w);
    endfunction

    // One-cycle memory: data for the address read last cycle, random junk otherwise.
    always @(posedge clk) mem_rdata <= mem_re ? mem_model(mem_raddr) : DW'($urandom());

    // Pop everything due by the current cycle into expected values (no comparing here).
    function automatic void sb_expect(output logic er, output logic [AW-1:0] ea,
                                      output logic [NP-1:0] ev, output logic [NP-1:0][DW-1:0] ed);
        iss_exp_t ie;
        rd_exp_t  re_e;
        er = 1'b0; ea = '0; ev = '0; ed = '0;
        while (iss_q.size() != 0 && iss_q[0].cyc <= cyc) begin
            ie = iss_q.pop_front();
            er = 1'b1; ea = ie.addr;
        end
        while (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
            re_e = rd_q.pop_front();
            ev[re_e.port] = 1'b1; ed[re_e.port] = re_e.data;
        end
    endfunction

    task automatic test_reset();
        logic er; logic [AW-1:0] ea; logic [NP-1:0] ev; logic [NP-1:0][DW-1:0] ed;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            sb_expect(er, ea, ev, ed);
            n_chk++; if (mem_re !== er) begin n_fail++; $display("FAIL reset mem_re cyc=%0d got=%b exp=%b", cyc, mem_re, er); end
            n_chk++; if (mem_raddr !== '0) begin n_fail++; $display("FAIL reset mem_raddr cyc=%0d got=%h exp=0", cyc, mem_raddr); end
            n_chk++; if (rvalid !== ev) begin n_fail++; $display("FAIL reset rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, ev); end
            for (int p = 0; p < NP; p++) begin
                n_chk++; if (rdata[p] !== ed[p]) begin n_fail++; $display("FAIL reset rdata[%0d] cyc=%0d got=%h exp=%h", p, cyc, rdata[p], ed[p]); end
            end
            if (k == 2) rst_n = 1'b1;
        end
    endtask

    task automatic test_single_port();
        logic er; logic [AW-1:0] ea; logic [NP-1:0] ev; logic [NP-1:0][DW-1:0] ed;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sb_expect(er, ea, ev, ed);
            n_chk++; if (mem_re !== er) begin n_fail++; $display("FAIL single mem_re cyc=%0d got=%b exp=%b", cyc, mem_re, er); end
            if (er) begin n_chk++; if (mem_raddr !== ea) begin n_fail++; $display("FAIL single mem_raddr cyc=%0d got=%h exp=%h", cyc, mem_raddr, ea); end end
            n_chk++; if (rvalid !== ev) begin n_fail++; $display("FAIL single rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, ev); end
            for (int p = 0; p < NP; p++) begin
                n_chk++; if (rdata[p] !== ed[p]) begin n_fail++; $display("FAIL single rdata[%0d] cyc=%0d got=%h exp=%h", p, cyc, rdata[p], ed[p]); end
            end
            if (k == 0) begin
                addr[2] = 8'h15; re[2] = 1'b1;
                iss_q.push_back('{cyc: cyc + 1, addr: 8'h15});
                rd_q.push_back('{cyc: cyc + 2 + OL, port: 2, data: mem_model(8'h15)});
            end
            if (k == 2 + OL) re[2] = 1'b0;
        end
    endtask

    task automatic test_all_ports();
        logic er; logic [AW-1:0] ea; logic [NP-1:0] ev; logic [NP-1:0][DW-1:0] ed;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sb_expect(er, ea, ev, ed);
            n_chk++; if (mem_re !== er) begin n_fail++; $display("FAIL all mem_re cyc=%0d got=%b exp=%b", cyc, mem_re, er); end
            if (er) begin n_chk++; if (mem_raddr !== ea) begin n_fail++; $display("FAIL all mem_raddr cyc=%0d got=%h exp=%h", cyc, mem_raddr, ea); end end
            n_chk++; if (rvalid !== ev) begin n_fail++; $display("FAIL all rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, ev); end
            for (int p = 0; p < NP; p++) begin
                n_chk++; if (rdata[p] !== ed[p]) begin n_fail++; $display("FAIL all rdata[%0d] cyc=%0d got=%h exp=%h", p, cyc, rdata[p], ed[p]); end
            end
            if (k == 0) rst_n = 1'b0;
            if (k == 1) rst_n = 1'b1;
            if (k == 2) begin
                for (int p = 0; p < NP; p++) begin
                    addr[p] = AW'(8'h40 + p); re[p] = 1'b1;
                    iss_q.push_back('{cyc: cyc + 1 + p, addr: AW'(8'h40 + p)});
                    rd_q.push_back('{cyc: cyc + 2 + p + OL, port: p, data: mem_model(AW'(8'h40 + p))});
                end
            end
            for (int p = 0; p < NP; p++) if (k == 4 + p + OL) re[p] = 1'b0;
        end
    endtask

    task automatic test_held_re();
        logic er; logic [AW-1:0] ea; logic [NP-1:0] ev; logic [NP-1:0][DW-1:0] ed;
        int per;
        per = 3 + OL;
        for (int k = 0; k < 3 * per + 5 + OL; k++) begin
            @(negedge clk);
            sb_expect(er, ea, ev, ed);
            n_chk++; if (mem_re !== er) begin n_fail++; $display("FAIL held mem_re cyc=%0d got=%b exp=%b", cyc, mem_re, er); end
            if (er) begin n_chk++; if (mem_raddr !== ea) begin n_fail++; $display("FAIL held mem_raddr cyc=%0d got=%h exp=%h", cyc, mem_raddr, ea); end end
            n_chk++; if (rvalid !== ev) begin n_fail++; $display("FAIL held rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, ev); end
            for (int p = 0; p < NP; p++) begin
                n_chk++; if (rdata[p] !== ed[p]) begin n_fail++; $display("FAIL held rdata[%0d] cyc=%0d got=%h exp=%h", p, cyc, rdata[p], ed[p]); end
            end
            if (k == 0) begin
                addr[1] = 8'h2A; re[1] = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    iss_q.push_back('{cyc: cyc + 1 + i * per, addr: 8'h2A});
                    rd_q.push_back('{cyc: cyc + 2 + OL + i * per, port: 1, data: mem_model(8'h2A)});
                end
            end
            if (k == 3 * per + 1) re[1] = 1'b0;
        end
    endtask

    task automatic test_early_drop();
        logic er; logic [AW-1:0] ea; logic [NP-1:0] ev; logic [NP-1:0][DW-1:0] ed;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            sb_expect(er, ea, ev, ed);
            n_chk++; if (mem_re !== er) begin n_fail++; $display("FAIL drop mem_re cyc=%0d got=%b exp=%b", cyc, mem_re, er); end
            if (er) begin n_chk++; if (mem_raddr !== ea) begin n_fail++; $display("FAIL drop mem_raddr cyc=%0d got=%h exp=%h", cyc, mem_raddr, ea); end end
            n_chk++; if (rvalid !== ev) begin n_fail++; $display("FAIL drop rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, ev); end
            for (int p = 0; p < NP; p++) begin
                n_chk++; if (rdata[p] !== ed[p]) begin n_fail++; $display("FAIL drop rdata[%0d] cyc=%0d got=%h exp=%h", p, cyc, rdata[p], ed[p]); end
            end
            if (k == 0) rst_n = 1'b0;
            if (k == 1) rst_n = 1'b1;
            if (k == 2) begin
                addr[0] = 8'h31; re[0] = 1'b1;
                addr[3] = 8'h73; re[3] = 1'b1;
                iss_q.push_back('{cyc: cyc + 1, addr: 8'h31});
                rd_q.push_back('{cyc: cyc + 2 + OL, port: 0, data: mem_model(8'h31)});
            end
            if (k == 3) begin
                re[0] = 1'b0;
                re[3] = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic er; logic [AW-1:0] ea; logic [NP-1:0] ev; logic [NP-1:0][DW-1:0] ed;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            sb_expect(er, ea, ev, ed);
            n_chk++; if (mem_re !== er) begin n_fail++; $display("FAIL midrst mem_re cyc=%0d got=%b exp=%b", cyc, mem_re, er); end
            if (er) begin n_chk++; if (mem_raddr !== ea) begin n_fail++; $display("FAIL midrst mem_raddr cyc=%0d got=%h exp=%h", cyc, mem_raddr, ea); end end
            n_chk++; if (rvalid !== ev) begin n_fail++; $display("FAIL midrst rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, ev); end
            for (int p = 0; p < NP; p++) begin
                n_chk++; if (rdata[p] !== ed[p]) begin n_fail++; $display("FAIL midrst rdata[%0d] cyc=%0d got=%h exp=%h", p, cyc, rdata[p], ed[p]); end
            end
            if (k == 2) begin
                n_chk++; if (mem_raddr !== '0) begin n_fail++; $display("FAIL midrst raddr_reset cyc=%0d got=%h exp=0", cyc, mem_raddr); end
            end
            if (k == 0) begin
                addr[1] = 8'h11; re[1] = 1'b1;
                iss_q.push_back('{cyc: cyc + 1, addr: 8'h11});
            end
            if (k == 1) begin
                re[1] = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b0;
            end
            if (k == 3) begin
                rst_n = 1'b1;
                addr[0] = 8'h05; re[0] = 1'b1;
                addr[2] = 8'h27; re[2] = 1'b1;
                iss_q.push_back('{cyc: cyc + 1, addr: 8'h05});
                iss_q.push_back('{cyc: cyc + 2, addr: 8'h27});
                rd_q.push_back('{cyc: cyc + 2 + OL, port: 0, data: mem_model(8'h05)});
                rd_q.push_back('{cyc: cyc + 3 + OL, port: 2, data: mem_model(8'h27)});
            end
            if (k == 5 + OL) re[0] = 1'b0;
            if (k == 6 + OL) re[2] = 1'b0;
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) addr[p] = '0;
        test_reset();
        test_single_port();
        test_all_ports();
        test_held_re();
        test_early_drop();
        test_reset_midflight();
        n_chk++;
        if (rd_q.size() != 0 || iss_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending rd=%0d iss=%0d exp=0", rd_q.size(), iss_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
